// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the handshaked MEM stage.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic size_t f3_size(input logic [2:0] f3);
        return size_t'(f3[1:0]);
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [2:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return lo[1:0] != 2'b00;
            default: return lo != 3'b000;
        endcase
    endfunction

    // Doubleword accesses and LWU only exist on a 64-bit datapath.
    function automatic logic illegal_f3(input logic [2:0] f3, input logic is_load,
                                        input int unsigned xlen);
        return (xlen == 32) && ((f3[1:0] == 2'b11) || (is_load && f3 == F3_WU));
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory port: variable-latency req/ready handshake with byte enables.
interface mem_stage_hs_if #(
    parameter int unsigned XLEN = 32
);
    logic                mem_req;
    logic                mem_we;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ready;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module lsu_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [XLEN-1:0]             store_data,
    input  logic [XLEN-1:0]             rdata,
    output logic [XLEN/8-1:0]           be,
    output logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             load_data
);
    localparam int unsigned NB = XLEN / 8;

    size_t           sz;
    logic            uns;
    logic [NB-1:0]   mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] zx;
    logic [XLEN-1:0] sx;

    always_comb begin
        sz  = f3_size(funct3);
        uns = funct3[2];

        case (sz)
            SZ_B:    mask = NB'(1);
            SZ_H:    mask = NB'(3);
            SZ_W:    mask = NB'(15);
            default: mask = '1;
        endcase
        be = mask << offset;

        case (sz)
            SZ_B:    wdata = {NB{store_data[7:0]}};
            SZ_H:    wdata = {(NB/2){store_data[15:0]}};
            SZ_W:    wdata = {(XLEN/32){store_data[31:0]}};
            default: wdata = store_data;
        endcase

        shifted = rdata >> {offset, 3'b000};
        case (sz)
            SZ_B: begin
                zx = XLEN'(shifted[7:0]);
                sx = XLEN'($signed(shifted[7:0]));
            end
            SZ_H: begin
                zx = XLEN'(shifted[15:0]);
                sx = XLEN'($signed(shifted[15:0]));
            end
            SZ_W: begin
                zx = XLEN'(shifted[31:0]);
                sx = XLEN'($signed(shifted[31:0]));
            end
            default: begin
                zx = shifted;
                sx = shifted;
            end
        endcase
        load_data = uns ? zx : sx;
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with a stalling req/ready data port, bus timeout and fault flags;
// owns the MEM/WB register and injects bubbles while an access is outstanding.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic [XLEN-1:0]     ALUoutM,
    input  logic [XLEN-1:0]     rs2M,
    input  logic [2:0]          funct3M,
    input  logic [4:0]          RdM,
    input  logic [XLEN-1:0]     inc_PCM,
    output logic                StallM,
    mem_stage_hs_if.master      dmem,
    output logic                RegWriteW,
    output logic [1:0]          ResultSrcW,
    output logic [XLEN-1:0]     ALUoutW,
    output logic [XLEN-1:0]     ReadDataW,
    output logic [4:0]          RdW,
    output logic [XLEN-1:0]     inc_PCW,
    output logic                MisalignW,
    output logic                BusErrW
);
    localparam int unsigned K = $clog2(XLEN / 8);

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic              access;
    logic              bad;
    logic              go;
    logic              req;
    logic              timeout_hit;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   load_data;

    assign access = MemReadM | MemWriteM;
    assign bad    = access & (misaligned(f3_size(funct3M), ALUoutM[2:0]) |
                              illegal_f3(funct3M, MemReadM, XLEN));
    assign go     = access & ~bad;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3     (funct3M),
        .offset     (ALUoutM[K-1:0]),
        .store_data (rs2M),
        .rdata      (dmem.mem_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    // Address and lane outputs follow the M inputs, which upstream holds while stalled.
    always_comb begin
        req         = ~rst & ((state == WAIT) | go);
        timeout_hit = (TIMEOUT != 0) && (state == WAIT) && (cnt == CNT_W'(TIMEOUT)) &&
                      !dmem.mem_ready;
        StallM      = req & ~dmem.mem_ready & ~timeout_hit;
    end

    assign dmem.mem_req   = req;
    assign dmem.mem_we    = req & MemWriteM;
    assign dmem.mem_addr  = {ALUoutM[XLEN-1:K], {K{1'b0}}};
    assign dmem.mem_be    = be;
    assign dmem.mem_wdata = wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUoutW    <= '0;
            ReadDataW  <= '0;
            RdW        <= 5'd0;
            inc_PCW    <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && !dmem.mem_ready) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem.mem_ready || timeout_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (StallM) begin
                // Bubble: nothing reaches writeback until the access resolves.
                RegWriteW  <= 1'b0;
                ResultSrcW <= 2'b00;
                ALUoutW    <= '0;
                ReadDataW  <= '0;
                RdW        <= 5'd0;
                inc_PCW    <= '0;
                MisalignW  <= 1'b0;
                BusErrW    <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM & ~bad & ~timeout_hit;
                ResultSrcW <= ResultSrcM;
                ALUoutW    <= ALUoutM;
                ReadDataW  <= (MemReadM && go && !timeout_hit) ? load_data : '0;
                RdW        <= RdM;
                inc_PCW    <= inc_PCM;
                MisalignW  <= bad;
                BusErrW    <= timeout_hit;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs (XLEN=32, TIMEOUT=4).
module tb_mem_stage_hs;
    import mem_pkg::*;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        mis;
        logic        berr;
    } w_t;

    typedef struct {
        w_t    val;
        w_t    care;
        string name;
    } exp_t;

    localparam w_t CARE_ALL    = '1;
    localparam w_t CARE_BUBBLE = '{rw: 1'b1, rs: 2'b00, alu: 32'h0, rdata: 32'h0, rd: 5'h1f,
                                   pc: 32'h0, mis: 1'b1, berr: 1'b1};
    localparam w_t CARE_NORD   = '{rw: 1'b1, rs: 2'b11, alu: 32'hffff_ffff, rdata: 32'h0,
                                   rd: 5'h1f, pc: 32'hffff_ffff, mis: 1'b1, berr: 1'b1};
    localparam w_t W_ZERO      = '0;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUoutM;
    logic [31:0] rs2M;
    logic [2:0]  funct3M;
    logic [4:0]  RdM;
    logic [31:0] inc_PCM;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUoutW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] inc_PCW;
    logic        MisalignW;
    logic        BusErrW;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] pc_v = 32'h0000_1000;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    mem_stage_hs_if #(.XLEN(32)) bus ();
    assign bus.mem_ready = ready;
    assign bus.mem_rdata = rdata;

    mem_stage_hs #(
        .XLEN    (32),
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUoutM    (ALUoutM),
        .rs2M       (rs2M),
        .funct3M    (funct3M),
        .RdM        (RdM),
        .inc_PCM    (inc_PCM),
        .StallM     (StallM),
        .dmem       (bus),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUoutW    (ALUoutW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .inc_PCW    (inc_PCW),
        .MisalignW  (MisalignW),
        .BusErrW    (BusErrW)
    );

    always #5 clk = ~clk;

    function automatic w_t w_now();
        return {RegWriteW, ResultSrcW, ALUoutW, ReadDataW, RdW, inc_PCW, MisalignW, BusErrW};
    endfunction

    function automatic w_t pass_w(input logic rw, input logic [31:0] rd_data);
        w_t w;
        w.rw = rw; w.rs = ResultSrcM; w.alu = ALUoutM; w.rdata = rd_data;
        w.rd = RdM; w.pc = inc_PCM; w.mis = 1'b0; w.berr = 1'b0;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w,
                                               input int off);
        logic [31:0] s;
        s = w >> (8 * off);
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'h0, s[7:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    task automatic drive(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        MemReadM = mr; MemWriteM = mw; RegWriteM = rw; funct3M = f3;
        ALUoutM = addr; rs2M = data; RdM = rd;
        ResultSrcM = mr ? 2'b01 : 2'b00;
        inc_PCM = pc_v;
        pc_v = pc_v + 32'd4;
    endtask

    task automatic push(input w_t v, input w_t c, input string n);
        exp_t e;
        e.val = v; e.care = c; e.name = n;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; ready = 1'b0; rdata = 32'h0;
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h104, 32'h0, 5'd4);
        @(negedge clk);
        checks++;
        if (bus.mem_req === 1'b0 && StallM === 1'b0) passed++;
        else $display("FAIL reset_req: req=%b stall=%b want 0/0", bus.mem_req, StallM);
        push(W_ZERO, CARE_ALL, "reset_w");
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ((w_now() & e.care) === (e.val & e.care)) passed++;
        else $display("FAIL %s: W got %h want %h", e.name, w_now() & e.care, e.val & e.care);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_lw_zero_wait();
        exp_t e;
        ready = 1'b1; rdata = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h104, 32'h0, 5'd5);
        @(negedge clk);
        checks++;
        if (StallM === 1'b0 && bus.mem_req === 1'b1 && bus.mem_we === 1'b0 &&
            bus.mem_addr === 32'h104 && bus.mem_be === 4'hF) passed++;
        else $display("FAIL lw0_bus: stall=%b req=%b we=%b addr=%h be=%b want 0/1/0/104/1111",
                      StallM, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
        push(pass_w(1'b1, 32'hDEAD_BEEF), CARE_ALL, "lw0_w");
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ((w_now() & e.care) === (e.val & e.care)) passed++;
        else $display("FAIL %s: W got %h want %h", e.name, w_now() & e.care, e.val & e.care);
    endtask

    task automatic test_lb_wait(input logic [2:0] f3, input logic [31:0] want, input string n);
        exp_t e;
        rdata = 32'h8011_2233;
        drive(1'b1, 1'b0, 1'b1, f3, 32'h103, 32'h0, 5'd9);
        for (int c = 0; c < 4; c++) begin
            ready = (c == 3);
            @(negedge clk);
            checks++;
            if (StallM === (c < 3) && bus.mem_req === 1'b1 && bus.mem_addr === 32'h100) passed++;
            else $display("FAIL %s_stall c%0d: stall=%b req=%b addr=%h want %b/1/100",
                          n, c, StallM, bus.mem_req, bus.mem_addr, c < 3);
            if (c < 3) push(W_ZERO, CARE_BUBBLE, {n, "_bubble"});
            else       push(pass_w(1'b1, want), CARE_ALL, {n, "_w"});
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ((w_now() & e.care) === (e.val & e.care)) passed++;
            else $display("FAIL %s c%0d: W got %h want %h", e.name, c, w_now() & e.care,
                          e.val & e.care);
        end
        ready = 1'b0;
    endtask

    task automatic test_sh();
        exp_t e;
        drive(1'b0, 1'b1, 1'b0, F3_H, 32'h102, 32'h0000_ABCD, 5'd0);
        for (int c = 0; c < 2; c++) begin
            ready = (c == 1);
            @(negedge clk);
            checks++;
            if (bus.mem_be === 4'b1100 && bus.mem_wdata === 32'hABCD_ABCD && bus.mem_we === 1'b1 &&
                bus.mem_addr === 32'h100 && StallM === (c == 0)) passed++;
            else $display("FAIL sh_bus c%0d: be=%b wd=%h we=%b addr=%h stall=%b", c, bus.mem_be,
                          bus.mem_wdata, bus.mem_we, bus.mem_addr, StallM);
            if (c == 0) push(W_ZERO, CARE_BUBBLE, "sh_bubble");
            else        push(pass_w(1'b0, 32'h0), CARE_NORD, "sh_w");
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ((w_now() & e.care) === (e.val & e.care)) passed++;
            else $display("FAIL %s: W got %h want %h", e.name, w_now() & e.care, e.val & e.care);
        end
        ready = 1'b0;
    endtask

    task automatic test_bad();
        exp_t        e;
        w_t          v;
        logic [2:0]  f3s  [2] = '{F3_W, F3_D};
        logic [31:0] adrs [2] = '{32'h101, 32'h100};
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, f3s[i], adrs[i], 32'h0, 5'd6);
            @(negedge clk);
            checks++;
            if (bus.mem_req === 1'b0 && StallM === 1'b0) passed++;
            else $display("FAIL bad%0d_req: req=%b stall=%b want 0/0", i, bus.mem_req, StallM);
            v = pass_w(1'b0, 32'h0);
            v.mis = 1'b1;
            push(v, CARE_NORD, "bad_w");
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ((w_now() & e.care) === (e.val & e.care)) passed++;
            else $display("FAIL %s%0d: W got %h want %h", e.name, i, w_now() & e.care,
                          e.val & e.care);
        end
        ready = 1'b0;
    endtask

    task automatic test_timeout();
        exp_t e;
        w_t   v;
        ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h200, 32'h0, 5'd12);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (StallM === (c < 4) && bus.mem_req === 1'b1) passed++;
            else $display("FAIL to_stall c%0d: stall=%b req=%b want %b/1", c, StallM,
                          bus.mem_req, c < 4);
            if (c < 4) begin
                push(W_ZERO, CARE_BUBBLE, "to_bubble");
            end else begin
                v = pass_w(1'b0, 32'h0);
                v.berr = 1'b1;
                push(v, CARE_NORD, "to_buserr");
            end
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ((w_now() & e.care) === (e.val & e.care)) passed++;
            else $display("FAIL %s c%0d: W got %h want %h", e.name, c, w_now() & e.care,
                          e.val & e.care);
        end
        drive(1'b0, 1'b0, 1'b1, F3_B, 32'h0000_1234, 32'h0, 5'd7);
        @(negedge clk);
        checks++;
        if (bus.mem_req === 1'b0 && StallM === 1'b0) passed++;
        else $display("FAIL to_add_req: req=%b stall=%b want 0/0", bus.mem_req, StallM);
        push(pass_w(1'b1, 32'h0), CARE_ALL, "to_add_w");
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if ((w_now() & e.care) === (e.val & e.care)) passed++;
        else $display("FAIL %s: W got %h want %h", e.name, w_now() & e.care, e.val & e.care);
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, F3_W, 32'h300, 32'h0, 5'd3);
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst = 1'b0;
                drive(1'b0, 1'b0, 1'b0, F3_B, 32'h0, 32'h0, 5'd0);
            end
            @(negedge clk);
            checks++;
            if (bus.mem_req === (c < 2) && StallM === (c < 2)) passed++;
            else $display("FAIL rw_req c%0d: req=%b stall=%b want %b/%b", c, bus.mem_req,
                          StallM, c < 2, c < 2);
            if (c < 2)       push(W_ZERO, CARE_BUBBLE, "rw_bubble");
            else if (c == 2) push(W_ZERO, CARE_ALL, "rw_reset");
            else             push(pass_w(1'b0, 32'h0), CARE_ALL, "rw_idle");
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ((w_now() & e.care) === (e.val & e.care)) passed++;
            else $display("FAIL %s c%0d: W got %h want %h", e.name, c, w_now() & e.care,
                          e.val & e.care);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        mrs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        mws [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{F3_H, F3_W, F3_BU, F3_B};
        logic [31:0] ads [4] = '{32'h106, 32'h10C, 32'h101, 32'h55AA};
        logic [31:0] wds [4] = '{32'h0, 32'h1122_3344, 32'h0, 32'h0};
        logic [31:0] rds [4] = '{32'h8000_1234, 32'h0, 32'h0000_FE00, 32'h0};
        logic [31:0] exr [4] = '{32'hFFFF_8000, 32'h0, 32'h0000_00FE, 32'h0};
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdata = rds[i];
            drive(mrs[i], mws[i], !mws[i], f3s[i], ads[i], wds[i], 5'(i + 16));
            @(negedge clk);
            checks++;
            if (StallM === 1'b0 && bus.mem_req === (mrs[i] | mws[i])) passed++;
            else $display("FAIL b2b%0d_req: stall=%b req=%b", i, StallM, bus.mem_req);
            if (mws[i]) begin
                checks++;
                if (bus.mem_be === 4'hF && bus.mem_wdata === 32'h1122_3344) passed++;
                else $display("FAIL b2b_sw: be=%b wd=%h want 1111/11223344", bus.mem_be,
                              bus.mem_wdata);
            end
            push(pass_w(!mws[i], exr[i]), mws[i] ? CARE_NORD : CARE_ALL, "b2b_w");
            @(posedge clk); #1;
            e = sb.pop_front(); checks++;
            if ((w_now() & e.care) === (e.val & e.care)) passed++;
            else $display("FAIL %s%0d: W got %h want %h", e.name, i, w_now() & e.care,
                          e.val & e.care);
        end
        ready = 1'b0;
    endtask

    task automatic test_lanes();
        exp_t        e;
        logic [2:0]  f3s [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] sd;
        ready = 1'b1;
        for (int off = 0; off < 4; off++) begin
            for (int j = 0; j < 4; j++) begin
                if (j >= 2 && off[0]) continue;
                rdata = $urandom;
                drive(1'b1, 1'b0, 1'b1, f3s[j], 32'h400 + 32'(off), 32'h0, 5'd20);
                push(pass_w(1'b1, model_load(f3s[j], rdata, off)), CARE_ALL, "lane_ld");
                @(posedge clk); #1;
                e = sb.pop_front(); checks++;
                if ((w_now() & e.care) === (e.val & e.care)) passed++;
                else $display("FAIL %s off%0d f3=%0d: W got %h want %h", e.name, off, f3s[j],
                              w_now() & e.care, e.val & e.care);
            end
            sd = $urandom;
            drive(1'b0, 1'b1, 1'b0, F3_B, 32'h500 + 32'(off), sd, 5'd0);
            @(negedge clk);
            checks++;
            if (bus.mem_be === 4'(1 << off) && bus.mem_wdata === {4{sd[7:0]}}) passed++;
            else $display("FAIL lane_sb off%0d: be=%b wd=%h want %b/%h", off, bus.mem_be,
                          bus.mem_wdata, 4'(1 << off), {4{sd[7:0]}});
            @(posedge clk); #1;
        end
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_wait(F3_B,  32'hFFFF_FF80, "lb");
        test_lb_wait(F3_BU, 32'h0000_0080, "lbu");
        test_sh();
        test_bad();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        test_lanes();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised successor to the pipeline MEM stage. It adds XLEN-generic load/store alignment, a variable-latency req/ready data-memory port, a stall output to the hazard unit, a bus timeout, and misalignment/bus-error flags. It sits between the EX/MEM register and the writeback mux. It drives the MEM/WB register internally and inserts bubbles while the memory access is outstanding.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. At 64, LD/SD/LWU are legal.
TIMEOUT, 0, maximum number of cycles in WAIT before abort. 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
RegWriteM  in  1  register-write enable from M
ResultSrcM  in  2  writeback select from M
MemReadM  in  1  load request
MemWriteM  in  1  store request
ALUoutM  in  XLEN  effective address / ALU result
rs2M  in  XLEN  store data
funct3M  in  3  access size and sign (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
RdM  in  5  destination register
inc_PCM  in  XLEN  PC+4
StallM  out  1  hold IF..M stages; combinational
mem_req  out  1  memory request
mem_we  out  1  write strobe
mem_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-replicated store data
mem_ready  in  1  transaction complete (rdata valid for loads)
mem_rdata  in  XLEN  raw read word
RegWriteW, ResultSrcW, ALUoutW, ReadDataW, RdW, inc_PCW  out  1/2/XLEN/XLEN/5/XLEN  MEM/WB register
MisalignW  out  1  access was misaligned or illegal for XLEN
BusErrW  out  1  access timed out

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. In a cycle where rst=1, every W output and both flags load 0 at the edge, state goes to IDLE, and the counter goes to 0. mem_req, mem_we, and StallM are forced to 0 while rst=1.
- Access detection: access = MemReadM|MemWriteM. An access is bad when it is misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0) or when funct3 is LD/SD/LWU with XLEN=32.
- States: IDLE and WAIT.
- IDLE, access, not bad: mem_req=1 this cycle.
  - mem_ready=1 in the same cycle: zero-wait completion. W loads the result and StallM=0.
  - Otherwise: StallM=1, go to WAIT, counter=1.
- WAIT: mem_req=1. mem_addr, mem_we, mem_be, and mem_wdata stay constant; upstream holds the M inputs because StallM=1.
  - mem_ready=1: W loads the result, StallM=0, go to IDLE.
  - Counter reaches TIMEOUT (TIMEOUT>0) with mem_ready=0: abort. W loads RegWriteW=0, BusErrW=1, RdW=RdM. StallM=0, go to IDLE.
  - Otherwise: counter increments.
- Bad access: no mem_req and no stall. W loads RegWriteW=0 and MisalignW=1; other fields pass through.
- No access: W loads the M fields directly; ReadDataW is don't-care and must be 0.
- Bubbles: on every cycle where StallM=1, W loads a bubble (RegWriteW=0, RdW=0, flags 0). Writeback is therefore never duplicated.
- Store lanes: mem_be sets the 1/2/4/8 bits at byte offset addr[k-1:0], where k=log2(XLEN/8). mem_wdata replicates rs2M's low byte, half, or word across all lanes.
- Load extraction: shift mem_rdata right by 8*offset, then sign- or zero-extend to XLEN according to funct3.
- Latency: a non-memory instruction takes 1 cycle M->W. A load or store takes 1 + N cycles, where N is the number of cycles mem_ready stays low.
- mem_ready while not requesting: ignored.

Decomposition:
- Package mem_pkg: funct3 load/store encodings, the state_t enum {IDLE, WAIT}, and size decode function(s).
- Sub-module lsu_align (combinational, parametrised by XLEN): generates be/wdata and performs load extraction and extension.
- FSM, counter, and W register stay in mem_stage_hs.

Test Plan:
- LW at 0x104 with mem_ready tied to 1 and mem_rdata=0xDEADBEEF: no StallM; next edge ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB at 0x103, mem_rdata=0x80112233, ready delayed 3 cycles: StallM high for 3 cycles and three bubbles in W (RegWriteW=0); then ReadDataW=0xFFFFFF80. Repeat with LBU: 0x00000080.
- SH at 0x102, rs2M=0x0000ABCD: mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, RegWriteW=0 after completion.
- LW at 0x101: no mem_req, no StallM, MisalignW=1, RegWriteW=0. With XLEN=32, LD at 0x100: same response.
- TIMEOUT=4 with mem_ready never asserted: StallM held for 4 cycles, then BusErrW=1, RegWriteW=0, state IDLE; a following ADD writes back normally.
- rst asserted during the 2nd WAIT cycle: at the next edge state=IDLE and all W outputs=0; mem_req is 0 while rst=1.
